// File: rtl/socket_controler_mc.sv
// Multi-channel socket FIFO read controller.
// Watches N_CH socket FIFOs and grants them one at a time in round-robin order.
// Each grant pulls a burst of up to BURST_LEN words into one shared consumer.
// The consumer can apply back-pressure through i_ready.
// MODE 0 (STREAM): a channel may be granted as soon as it holds any data,
// and a burst ends early when its FIFO runs dry.
// MODE 1 (FRAME): a channel may be granted only when its FIFO is full,
// and a burst waits out gaps in the data instead of ending early.
module socket_controler_mc #(
  parameter  int N_CH      = 4,
  parameter  int BURST_LEN = 16,
  parameter  int MODE      = 0,
  localparam int CW        = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int KW        = $clog2(BURST_LEN + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_empty,
  input  logic [N_CH-1:0] i_full,
  input  logic            i_ready,
  output logic [N_CH-1:0] o_rd_en,
  output logic [CW-1:0]   o_ch_idx,
  output logic            o_busy,
  output logic [KW-1:0]   o_rd_cnt,
  output logic            o_burst_done
);

  typedef enum logic [1:0] {IDLE, PULL, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   grant;
  logic [CW-1:0]   last_grant;
  logic [KW-1:0]   rd_cnt;
  logic            burst_done;
  logic [N_CH-1:0] eligible;
  logic            pick_valid;
  logic [CW-1:0]   pick_idx;
  logic [CW-1:0]   cand;
  logic            rd_fire;

  assign eligible = (MODE == 1) ? i_full : ~i_empty;

  // A read happens only on the granted channel, when the consumer can take
  // the word and the FIFO still holds data, so a FIFO can never underflow.
  assign rd_fire = (state == PULL) && i_ready && !i_empty[grant];

  // Round-robin choice: the first eligible channel after last_grant, with wrap-around.
  always_comb begin
    // NOTE: every output of this block gets a default first, so every path
    // assigns it and no latch is inferred.
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    // Scan from the farthest offset down to the nearest one. The nearest
    // eligible channel is the last one written, so it wins.
    for (int k = N_CH; k >= 1; k--) begin
      cand = CW'((int'(last_grant) + k) % N_CH);
      if (eligible[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Read enable is decoded from the registered grant and the live FIFO and consumer flags.
  always_comb begin
    o_rd_en = '0;
    if (state == PULL) o_rd_en[grant] = rd_fire;
  end

  // Controller state machine together with its registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      // Start from the top channel so that the first search begins at channel 0.
      last_grant <= CW'(N_CH - 1);
      rd_cnt     <= '0;
      burst_done <= 1'b0;
    end else begin
      // NOTE: this block holds state, so it uses only non-blocking assignments.
      // Every register then updates from values sampled before the clock edge.
      burst_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            state      <= PULL;
            grant      <= pick_idx;
            last_grant <= pick_idx;
            rd_cnt     <= '0;
          end
        end
        PULL: begin
          if (rd_fire) begin
            rd_cnt <= rd_cnt + 1'b1;
            // The final read of a full burst wins over an empty flag that
            // rises in the same cycle.
            if (rd_cnt == KW'(BURST_LEN - 1)) begin
              state      <= DONE;
              burst_done <= 1'b1;
            end
          end else if (MODE == 0 && i_empty[grant]) begin
            // STREAM mode: a dry FIFO ends the burst early, with a short count.
            state      <= DONE;
            burst_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ch_idx     = grant;
  assign o_busy       = (state != IDLE);
  assign o_rd_cnt     = rd_cnt;
  assign o_burst_done = burst_done;

endmodule

// File: tb/tb_socket_controler_mc.sv
// Bench for socket_controler_mc.
// One instance runs in STREAM mode and one in FRAME mode, both with BURST_LEN=4.
// The bench keeps a word count for each FIFO and drives the empty and full
// flags from those counts.
// The expected grant order, burst length and burst duration come from the
// round-robin and burst rules applied to those counts.
module tb_socket_controler_mc;
  localparam int N  = 4;
  localparam int BL = 4;
  localparam int CW = 2;
  localparam int KW = 3;
  localparam int DEPTH1 = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]  e0, f0, e1, f1, rd0, rd1;
  logic          r0, r1, busy0, busy1, done0, done1;
  logic [CW-1:0] idx0, idx1;
  logic [KW-1:0] cnt0, cnt1;

  socket_controler_mc #(.N_CH(N), .BURST_LEN(BL), .MODE(0)) dut_stream (
    .i_clk(clk), .i_rst_n(rst_n), .i_empty(e0), .i_full(f0), .i_ready(r0),
    .o_rd_en(rd0), .o_ch_idx(idx0), .o_busy(busy0), .o_rd_cnt(cnt0),
    .o_burst_done(done0));

  socket_controler_mc #(.N_CH(N), .BURST_LEN(BL), .MODE(1)) dut_frame (
    .i_clk(clk), .i_rst_n(rst_n), .i_empty(e1), .i_full(f1), .i_ready(r1),
    .o_rd_en(rd1), .o_ch_idx(idx1), .o_busy(busy1), .o_rd_cnt(cnt1),
    .o_burst_done(done1));

  int q0[N];
  int q1[N];
  int total = 0;
  int bad = 0;
  int viol = 0;
  int m_last0 = N - 1;
  int m_last1 = N - 1;
  bit pat[$];

  // Drive the FIFO flags from the modelled word counts.
  task automatic drive();
    for (int c = 0; c < N; c++) begin
      e0[c] = (q0[c] == 0);
      f0[c] = (q0[c] >= 16);
      e1[c] = (q1[c] == 0);
      f1[c] = (q1[c] >= DEPTH1);
    end
  endtask

  // Advance one clock and retire the reads granted during it.
  // Also record any read made on an empty FIFO, while the consumer is not
  // ready, or on more than one channel at once.
  task automatic step();
    logic [N-1:0] s0, s1;
    s0 = rd0;
    s1 = rd1;
    for (int c = 0; c < N; c++) begin
      if (s0[c] && (q0[c] == 0 || !r0)) viol++;
      if (s1[c] && (q1[c] == 0 || !r1)) viol++;
    end
    if ($countones(s0) > 1 || $countones(s1) > 1) viol++;
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      if (s0[c]) q0[c]--;
      if (s1[c]) q1[c]--;
    end
    drive();
    @(negedge clk);
  endtask

  function automatic int rr_pick(int last, logic [N-1:0] elig);
    for (int k = 1; k <= N; k++)
      if (elig[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] elig0();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = (q0[c] > 0);
    return v;
  endfunction

  // Predicted number of PULL cycles: walk the ready pattern until len reads
  // have happened. A short burst needs one more cycle to see the empty FIFO.
  function automatic int exp_cyc(int len, bit short_b);
    int pos = 0;
    int ones = 0;
    bit b = 1'b1;
    while (ones < len) begin
      if (pos < pat.size()) b = pat[pos];
      pos++;
      if (b) ones++;
    end
    return pos + (short_b ? 1 : 0);
  endfunction

  // Predict the next STREAM-mode burst from the current counts, then advance the model.
  task automatic predict(output int ech, output int elen, output int ecyc);
    ech = rr_pick(m_last0, elig0());
    m_last0 = ech;
    elen = (q0[ech] < BL) ? q0[ech] : BL;
    ecyc = exp_cyc(elen, q0[ech] < BL);
  endtask

  // Follow one STREAM-mode burst from IDLE through DONE and back to IDLE.
  // Every wait is bounded by a cycle budget.
  task automatic observe(output int ch, output int len, output int nreads,
                         output int cycles, output int wait_cyc,
                         output logic [N-1:0] rd_or, output logic done_after,
                         output logic busy_after, output bit timeout);
    int n = 0;
    timeout = 0; wait_cyc = 0; nreads = 0; cycles = 0; rd_or = '0;
    ch = -1; len = -1; done_after = 1'b1; busy_after = 1'b1;
    while (!busy0 && n < 200) begin step(); n++; wait_cyc++; end
    if (!busy0) begin timeout = 1; return; end
    ch = int'(idx0);
    while (!done0 && n < 200) begin
      if (pat.size() > 0) begin r0 = pat.pop_front(); #1; end
      if (rd0 != '0) nreads++;
      rd_or |= rd0;
      cycles++;
      step();
      n++;
    end
    if (!done0) begin timeout = 1; return; end
    len = int'(cnt0);
    step();
    done_after = done0;
    busy_after = busy0;
  endtask

  task automatic drain0();
    for (int c = 0; c < N; c++) q0[c] = 0;
    drive();
    pat.delete();
    r0 = 1'b1;
    repeat (4) step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_last0 = N - 1;
    m_last1 = N - 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    r0 = 1'b1;
    r1 = 1'b1;
    for (int c = 0; c < N; c++) begin q0[c] = 0; q1[c] = 0; end
    drive();
    repeat (2) @(negedge clk);
    total++; if ({rd0, idx0, busy0, cnt0, done0} !== '0) begin bad++;
      $display("FAIL reset_stream: got %h want 0", {rd0, idx0, busy0, cnt0, done0}); end
    total++; if ({rd1, idx1, busy1, cnt1, done1} !== '0) begin bad++;
      $display("FAIL reset_frame: got %h want 0", {rd1, idx1, busy1, cnt1, done1}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_channel();
    int ech, elen, ecyc, ch, len, nr, cy, wc;
    logic [N-1:0] ro;
    logic da, ba;
    bit to;
    q0[2] = 10;
    drive();
    for (int b = 0; b < 2; b++) begin
      predict(ech, elen, ecyc);
      observe(ch, len, nr, cy, wc, ro, da, ba, to);
      total++; if (to) begin bad++; $display("FAIL single_timeout: burst %0d got timeout want done", b); end
      total++; if (ch !== ech) begin bad++; $display("FAIL single_ch: got %0d want %0d", ch, ech); end
      total++; if (ro !== N'(1 << ech)) begin bad++; $display("FAIL single_rd_en: got %b want %b", ro, N'(1 << ech)); end
      total++; if (len !== elen || nr !== elen) begin bad++;
        $display("FAIL single_len: got cnt=%0d reads=%0d want %0d", len, nr, elen); end
      total++; if (cy !== ecyc) begin bad++; $display("FAIL single_cycles: got %0d want %0d", cy, ecyc); end
      total++; if (da !== 1'b0 || ba !== 1'b0) begin bad++;
        $display("FAIL single_pulse: got done=%b busy=%b want 0 0", da, ba); end
      total++; if (wc !== 1) begin bad++; $display("FAIL single_gap: got %0d want 1", wc); end
    end
    drain0();
  endtask

  task automatic test_early_done();
    int ech, elen, ecyc, ch, len, nr, cy, wc;
    logic [N-1:0] ro;
    logic da, ba;
    bit to;
    q0[1] = 2;
    drive();
    predict(ech, elen, ecyc);
    observe(ch, len, nr, cy, wc, ro, da, ba, to);
    total++; if (to) begin bad++; $display("FAIL early_timeout: got timeout want done"); end
    total++; if (ch !== ech) begin bad++; $display("FAIL early_ch: got %0d want %0d", ch, ech); end
    total++; if (len !== elen || nr !== elen) begin bad++;
      $display("FAIL early_len: got cnt=%0d reads=%0d want %0d", len, nr, elen); end
    total++; if (cy !== ecyc) begin bad++; $display("FAIL early_cycles: got %0d want %0d", cy, ecyc); end
    total++; if (da !== 1'b0) begin bad++; $display("FAIL early_pulse: got done=%b want 0", da); end
    drain0();
  endtask

  task automatic test_round_robin();
    int ech, elen, ecyc, ch, len, nr, cy, wc;
    logic [N-1:0] ro;
    logic da, ba;
    bit to;
    apply_reset();
    for (int c = 0; c < N; c++) q0[c] = 20;
    drive();
    for (int b = 0; b < 5; b++) begin
      predict(ech, elen, ecyc);
      observe(ch, len, nr, cy, wc, ro, da, ba, to);
      total++; if (to) begin bad++; $display("FAIL rr_timeout: burst %0d got timeout want done", b); end
      total++; if (ch !== ech) begin bad++; $display("FAIL rr_ch: burst %0d got %0d want %0d", b, ch, ech); end
      total++; if (nr !== elen || len !== elen) begin bad++;
        $display("FAIL rr_len: burst %0d got %0d/%0d want %0d", b, nr, len, elen); end
      total++; if (wc !== 1) begin bad++; $display("FAIL rr_gap: burst %0d got %0d want 1", b, wc); end
    end
    drain0();
  endtask

  task automatic test_ready_toggle();
    int ech, elen, ecyc, ch, len, nr, cy, wc;
    logic [N-1:0] ro;
    logic da, ba;
    bit to;
    q0[0] = 10;
    drive();
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    predict(ech, elen, ecyc);
    observe(ch, len, nr, cy, wc, ro, da, ba, to);
    total++; if (to) begin bad++; $display("FAIL ready_timeout: got timeout want done"); end
    total++; if (cy !== ecyc) begin bad++; $display("FAIL ready_cycles: got %0d want %0d", cy, ecyc); end
    total++; if (len !== elen || nr !== elen) begin bad++;
      $display("FAIL ready_len: got cnt=%0d reads=%0d want %0d", len, nr, elen); end
    drain0();
  endtask

  task automatic test_frame();
    int seen = 0;
    int ech;
    logic [N-1:0] fv;
    q1[3] = 3;
    drive();
    repeat (3) begin step(); seen += int'(busy1); end
    total++; if (seen !== 0) begin bad++; $display("FAIL frame_not_full: got busy for %0d cycles want 0", seen); end
    q1[3] = DEPTH1;
    drive();
    for (int c = 0; c < N; c++) fv[c] = (q1[c] >= DEPTH1);
    ech = rr_pick(m_last1, fv);
    m_last1 = ech;
    step();
    total++; if (busy1 !== 1'b1 || int'(idx1) !== ech || rd1 !== N'(1 << ech)) begin bad++;
      $display("FAIL frame_grant: got busy=%b idx=%0d rd=%b want 1 %0d %b", busy1, idx1, rd1, ech, N'(1 << ech)); end
    step();
    step();
    total++; if (cnt1 !== KW'(2)) begin bad++; $display("FAIL frame_cnt2: got %0d want 2", cnt1); end
    q1[3] = 0;
    drive();
    #1;
    total++; if (rd1 !== '0) begin bad++; $display("FAIL frame_no_underflow: got %b want 0", rd1); end
    step();
    total++; if ({busy1, done1, cnt1} !== {1'b1, 1'b0, KW'(2)}) begin bad++;
      $display("FAIL frame_stall: got busy=%b done=%b cnt=%0d want 1 0 2", busy1, done1, cnt1); end
    q1[3] = 2;
    drive();
    step();
    step();
    total++; if (done1 !== 1'b1 || cnt1 !== KW'(BL)) begin bad++;
      $display("FAIL frame_done: got done=%b cnt=%0d want 1 %0d", done1, cnt1, BL); end
    step();
    total++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin bad++;
      $display("FAIL frame_idle: got done=%b busy=%b want 0 0", done1, busy1); end
  endtask

  task automatic test_random();
    int ech, elen, ecyc, ch, len, nr, cy, wc;
    logic [N-1:0] ro;
    logic da, ba;
    bit to;
    int any;
    for (int it = 0; it < 20; it++) begin
      any = 0;
      for (int c = 0; c < N; c++) begin
        q0[c] += $urandom_range(0, 3);
        any += q0[c];
      end
      if (any == 0) q0[$urandom_range(0, N - 1)] = 1;
      drive();
      pat.delete();
      repeat ($urandom_range(0, 5)) pat.push_back(1'($urandom_range(0, 1)));
      pat.push_back(1'b1);
      predict(ech, elen, ecyc);
      observe(ch, len, nr, cy, wc, ro, da, ba, to);
      pat.delete();
      r0 = 1'b1;
      total++; if (to || ch !== ech || len !== elen || nr !== elen || cy !== ecyc || da !== 1'b0) begin bad++;
        $display("FAIL rand_burst: it %0d got to=%0d ch=%0d len=%0d rd=%0d cyc=%0d want ch=%0d len=%0d cyc=%0d",
                 it, to, ch, len, nr, cy, ech, elen, ecyc); end
    end
    drain0();
  endtask

  task automatic test_reset_mid_burst();
    int ech, elen, ecyc, ch, len, nr, cy, wc, n;
    logic [N-1:0] ro;
    logic da, ba;
    bit to;
    q0[1] = 10;
    drive();
    n = 0;
    while (!busy0 && n < 20) begin step(); n++; end
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL midrst_start: got busy=%b want 1", busy0); end
    step();
    step();
    total++; if (cnt0 !== KW'(2)) begin bad++; $display("FAIL midrst_cnt: got %0d want 2", cnt0); end
    rst_n = 1'b0;
    #1;
    total++; if ({rd0, idx0, busy0, cnt0, done0} !== '0) begin bad++;
      $display("FAIL midrst_outputs: got %h want 0", {rd0, idx0, busy0, cnt0, done0}); end
    for (int c = 0; c < N; c++) q0[c] = 0;
    q0[0] = 5;
    q0[3] = 5;
    drive();
    repeat (2) @(negedge clk);
    total++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin bad++;
      $display("FAIL midrst_hold: got done=%b busy=%b want 0 0", done0, busy0); end
    rst_n = 1'b1;
    m_last0 = N - 1;
    m_last1 = N - 1;
    predict(ech, elen, ecyc);
    observe(ch, len, nr, cy, wc, ro, da, ba, to);
    total++; if (to || ch !== ech) begin bad++; $display("FAIL midrst_regrant: got %0d want %0d", ch, ech); end
    total++; if (len !== elen) begin bad++; $display("FAIL midrst_len: got %0d want %0d", len, elen); end
    drain0();
  endtask

  task automatic test_invariants();
    total++; if (viol !== 0) begin bad++;
      $display("FAIL rd_en_safety: got %0d illegal reads want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_early_done();
    test_round_robin();
    test_ready_toggle();
    test_frame();
    test_random();
    test_reset_mid_burst();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/socket_controler_mc.md
Name: socket_controler_mc

Overview:
- Parametrised, multi-channel successor to the single-FIFO socket read controller.
- Watches the full/empty flags of N_CH input socket FIFOs and grants one channel at a time, round-robin.
- Pulls a burst of up to BURST_LEN words from the granted channel into one shared downstream consumer, honouring consumer back-pressure.
- Sits between the socket FIFOs and the processing-module input mux.

Parameters:
- N_CH, 4, number of socket FIFO channels (1..16).
- BURST_LEN, 16, maximum words pulled per grant (≥1).
- MODE, 0, 0 = STREAM (channel eligible when not empty); 1 = FRAME (channel eligible only when full).

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_empty  in  N_CH  per-channel FIFO empty flag.
- i_full  in  N_CH  per-channel FIFO full flag.
- i_ready  in  1  downstream consumer can accept a word this cycle.
- o_rd_en  out  N_CH  one-hot (or zero) FIFO read enable.
- o_ch_idx  out  max(1,$clog2(N_CH))  index of the granted channel, driving the data mux.
- o_busy  out  1  high while in PULL or DONE.
- o_rd_cnt  out  $clog2(BURST_LEN+1)  words read in the current/last burst.
- o_burst_done  out  1  one-cycle pulse at the end of every burst.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values (i_rst_n low, asynchronous):
  - state = IDLE.
  - o_rd_en = 0, o_busy = 0, o_rd_cnt = 0, o_burst_done = 0.
  - o_ch_idx = 0.
  - Internal last_grant = N_CH-1, so channel 0 has top priority after reset.
- Reset asserted mid-burst aborts immediately; no o_burst_done pulse.
- eligible[c] = (MODE==1) ? i_full[c] : ~i_empty[c].
- State machine (registered state):
  - IDLE: if any eligible, pick the first eligible channel searching upward from last_grant+1 with wrap-around. Next cycle: PULL, grant and o_ch_idx register the choice, last_grant updated, o_rd_cnt cleared to 0. If none eligible, stay in IDLE.
  - PULL: o_rd_en[grant] = i_ready & ~i_empty[grant], combinational (Mealy) from registered grant and live inputs; all other bits 0. Every cycle with o_rd_en set, o_rd_cnt increments.
    - To DONE when a read occurs with o_rd_cnt == BURST_LEN-1 (burst complete).
    - STREAM mode: to DONE when i_empty[grant] is high and no read occurs (early termination, short burst).
    - FRAME mode: empty mid-burst stalls (o_rd_en low), staying in PULL until data arrives or the burst completes.
    - i_ready low: stall in PULL, no read, no count change.
  - DONE: o_burst_done = 1 for exactly one cycle, o_rd_en = 0, o_rd_cnt holds the final count. Next state IDLE.
- Latency: eligibility seen in IDLE → first o_rd_en possible 1 cycle later. Back-to-back grants have a 2-cycle gap (DONE + IDLE).
- o_busy = (state != IDLE).
- o_ch_idx holds its value outside PULL/DONE.
- Arbitration fairness: a channel granted once is not granted again while another channel stays continuously eligible, until all other eligible channels have been served.
- Simultaneous events in the same cycle:
  - Final read and i_empty rising: burst is complete → DONE.
  - In IDLE, eligibility of multiple channels: resolved purely by round-robin order.
- N_CH = 1: o_ch_idx is 1 bit, tied to 0; arbitration is trivial.
- o_rd_en is never asserted for a channel whose i_empty is high, so FIFO underflow is impossible.

Test Plan:
- Reset, then N_CH=4, MODE=0, BURST_LEN=4, i_ready=1; ch2 holds 10 words, others empty → grant ch2, o_rd_en=4'b0100 for 4 consecutive cycles, o_rd_cnt=4, o_burst_done pulse, then IDLE, then regrant ch2.
- MODE=0, ch1 holds 2 words, BURST_LEN=4 → 2 reads, early DONE with o_rd_cnt=2, one o_burst_done pulse, no read on an empty FIFO.
- All 4 channels non-empty continuously → grant order 0,1,2,3,0 with o_ch_idx matching; each burst exactly 4 reads.
- i_ready toggled 1,0,0,1,1,1 during a burst → o_rd_en follows i_ready, burst stretches to 6 cycles, o_rd_cnt=4.
- MODE=1, ch3 holds 3 words (not full) → stays IDLE, o_busy=0; when i_full[3] rises → grant ch3 1 cycle later. Empty pulsed mid-burst → stall, not early exit.
- i_rst_n low during PULL after 2 reads → outputs immediately 0. After release, with ch0 and ch3 eligible, ch0 is granted first.
